// File: rtl/jtpinpon_objscan_if.sv
// Draw-request bus between the object scanner and the sprite draw stage.
// The scanner (master) presents one sprite at a time with draw high.
// The draw stage (slave) accepts the sprite on the first cen2 edge where busy is low.
interface jtpinpon_objscan_if;
  logic       draw;
  logic       busy;
  logic [7:0] xpos;
  logic [3:0] ysub;
  logic [4:0] pal;
  logic       hflip;
  logic       vflip;
  logic [7:0] code;

  modport master (
    output draw, xpos, ysub, pal, hflip, vflip, code,
    input  busy
  );

  modport slave (
    input  draw, xpos, ysub, pal, hflip, vflip, code,
    output busy
  );
endinterface

// File: rtl/jtpinpon_objscan.sv
// Object-table scanner.
// On every line start it walks the object RAM from OBJMAX down to 0 and
// Y-tests each entry against the line being rendered. For each hit it
// fetches the attribute, code and X bytes, then issues one draw request.
module jtpinpon_objscan #(
  parameter logic [7:0] VOFFSET = 8'd0,
  parameter logic [4:0] OBJMAX  = 5'd31
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 cen2,
  input  logic                 hinit_x,
  input  logic [7:0]           vrender,
  output logic [6:0]           obj_addr,
  input  logic [7:0]           obj_dout,
  output logic                 done,
  jtpinpon_objscan_if.master   dbus
);

  typedef enum logic [2:0] {IDLE, RY, RA, RC, RX, ISS} state_t;

  state_t     state_reg, state_next;
  logic [4:0] index_reg, index_next;
  logic [6:0] addr_reg,  addr_next;
  logic       done_reg,  done_next;
  logic       draw_reg,  draw_next;
  logic [7:0] xpos_reg,  xpos_next;
  logic [3:0] ysub_reg,  ysub_next;
  logic [4:0] pal_reg,   pal_next;
  logic       hflip_reg, hflip_next;
  logic       vflip_reg, vflip_next;
  logic [7:0] code_reg,  code_next;

  // Line offset of the current object; wraps modulo 256 so sprites
  // straddling the top of the screen still hit.
  logic [7:0] diff;
  assign diff = vrender + VOFFSET - obj_dout;

  // Register all scanner state; next values already hold when cen2 is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      index_reg <= 5'd0;
      addr_reg  <= 7'd0;
      done_reg  <= 1'b1;
      draw_reg  <= 1'b0;
      xpos_reg  <= 8'd0;
      ysub_reg  <= 4'd0;
      pal_reg   <= 5'd0;
      hflip_reg <= 1'b0;
      vflip_reg <= 1'b0;
      code_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      addr_reg  <= addr_next;
      done_reg  <= done_next;
      draw_reg  <= draw_next;
      xpos_reg  <= xpos_next;
      ysub_reg  <= ysub_next;
      pal_reg   <= pal_next;
      hflip_reg <= hflip_next;
      vflip_reg <= vflip_next;
      code_reg  <= code_next;
    end
  end

  // Next-state logic: scan walk, byte fetches and the draw handshake.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    addr_next  = addr_reg;
    done_next  = done_reg;
    draw_next  = draw_reg;
    xpos_next  = xpos_reg;
    ysub_next  = ysub_reg;
    pal_next   = pal_reg;
    hflip_next = hflip_reg;
    vflip_next = vflip_reg;
    code_next  = code_reg;
    if (cen2) begin
      if (hinit_x) begin
        // Line start: from idle this begins a scan, otherwise it restarts it.
        state_next = RY;
        index_next = OBJMAX;
        addr_next  = {OBJMAX, 2'd0};
        done_next  = 1'b0;
        draw_next  = 1'b0;
      end else begin
        case (state_reg)
          RY: begin
            if (diff[7:4] == 4'd0) begin
              ysub_next  = diff[3:0];
              addr_next  = addr_reg + 7'd1;
              state_next = RA;
            end else if (index_reg == 5'd0) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              index_next = index_reg - 5'd1;
              addr_next  = {index_reg - 5'd1, 2'd0};
            end
          end
          RA: begin
            vflip_next = obj_dout[7];
            hflip_next = obj_dout[6];
            pal_next   = obj_dout[4:0];
            addr_next  = addr_reg + 7'd1;
            state_next = RC;
          end
          RC: begin
            code_next  = obj_dout;
            addr_next  = addr_reg + 7'd1;
            state_next = RX;
          end
          RX: begin
            xpos_next  = obj_dout;
            draw_next  = 1'b1;
            state_next = ISS;
          end
          ISS: begin
            // The draw stage takes the request on the first edge with busy low.
            if (!dbus.busy) begin
              draw_next = 1'b0;
              if (index_reg == 5'd0) begin
                done_next  = 1'b1;
                state_next = IDLE;
              end else begin
                index_next = index_reg - 5'd1;
                addr_next  = {index_reg - 5'd1, 2'd0};
                state_next = RY;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign obj_addr   = addr_reg;
  assign done       = done_reg;
  assign dbus.draw  = draw_reg;
  assign dbus.xpos  = xpos_reg;
  assign dbus.ysub  = ysub_reg;
  assign dbus.pal   = pal_reg;
  assign dbus.hflip = hflip_reg;
  assign dbus.vflip = vflip_reg;
  assign dbus.code  = code_reg;

endmodule

// File: tb/tb_jtpinpon_objscan.sv
// Testbench for jtpinpon_objscan: object RAM model, scoreboard of expected
// draw acceptances, directed scenarios followed by randomized lines.
module tb_jtpinpon_objscan;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen2;
  logic       hinit_x;
  logic [7:0] vrender;
  logic [6:0] obj_addr;
  logic [7:0] obj_dout;
  logic       done;

  jtpinpon_objscan_if dbus();

  jtpinpon_objscan dut (
    .rst      (rst),
    .clk      (clk),
    .cen2     (cen2),
    .hinit_x  (hinit_x),
    .vrender  (vrender),
    .obj_addr (obj_addr),
    .obj_dout (obj_dout),
    .done     (done),
    .dbus     (dbus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [128];
  assign obj_dout = ram[obj_addr];

  typedef struct {
    int         idx;
    logic [3:0] ysub;
    logic [7:0] attr;
    logic [7:0] code;
    logic [7:0] x;
  } exp_t;

  exp_t exp_q[$];
  int n_checks  = 0;
  int n_errors  = 0;
  int acc_count = 0;
  int busy_mode = 0;   // 0: never busy, 1: random, 2: always busy
  int cen_mode  = 0;   // 0: every other clock, 1: random

  // Clock-enable generator.
  initial begin
    cen2 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cen_mode == 0) cen2 = ~cen2;
      else               cen2 = ($urandom_range(0, 2) != 0);
    end
  end

  // Draw-stage busy generator.
  initial begin
    dbus.busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (busy_mode)
        0:       dbus.busy = 1'b0;
        1:       dbus.busy = 1'($urandom_range(0, 1));
        default: dbus.busy = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every acceptance and checks that the
  // sprite outputs stay frozen while a request is pending.
  initial begin
    logic       pdraw;
    logic [7:0] px, pc;
    logic [3:0] py;
    logic [4:0] pp;
    logic       ph, pv;
    exp_t       e;
    pdraw = 1'b0;
    px = 0; pc = 0; py = 0; pp = 0; ph = 0; pv = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pdraw = 1'b0;
      end else begin
        if (pdraw && dbus.draw) begin
          n_checks++;
          if ({px, pc, py, pp, ph, pv} !== {dbus.xpos, dbus.code, dbus.ysub, dbus.pal, dbus.hflip, dbus.vflip}) begin
            n_errors++;
            $display("FAIL stable: outputs changed during draw, x=%h code=%h ysub=%h pal=%h, required x=%h code=%h ysub=%h pal=%h",
                     dbus.xpos, dbus.code, dbus.ysub, dbus.pal, px, pc, py, pp);
          end
        end
        if (cen2 && dbus.draw && !dbus.busy) begin
          n_checks++;
          acc_count++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_draw: x=%h code=%h ysub=%h, required no acceptance", dbus.xpos, dbus.code, dbus.ysub);
          end else begin
            e = exp_q.pop_front();
            if (dbus.xpos !== e.x || dbus.code !== e.code || dbus.ysub !== e.ysub ||
                dbus.pal !== e.attr[4:0] || dbus.hflip !== e.attr[6] || dbus.vflip !== e.attr[7]) begin
              n_errors++;
              $display("FAIL accept obj %0d: got x=%h code=%h ysub=%h pal=%h h=%b v=%b, required x=%h code=%h ysub=%h pal=%h h=%b v=%b",
                       e.idx, dbus.xpos, dbus.code, dbus.ysub, dbus.pal, dbus.hflip, dbus.vflip,
                       e.x, e.code, e.ysub, e.attr[4:0], e.attr[6], e.attr[7]);
            end else begin
              $display("accept obj %0d: x=%h code=%h ysub=%h pal=%h h=%b v=%b",
                       e.idx, dbus.xpos, dbus.code, dbus.ysub, dbus.pal, dbus.hflip, dbus.vflip);
            end
          end
        end
        pdraw = dbus.draw;
        px = dbus.xpos; pc = dbus.code; py = dbus.ysub;
        pp = dbus.pal;  ph = dbus.hflip; pv = dbus.vflip;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: every object whose 16-line span covers the line is
  // drawn, highest index first.
  task automatic push_scan(input logic [7:0] vr);
    logic [7:0] d;
    exp_t e;
    for (int i = 31; i >= 0; i--) begin
      d = vr - ram[4*i];
      if (d < 8'd16) begin
        e.idx = i; e.ysub = d[3:0]; e.attr = ram[4*i+1];
        e.code = ram[4*i+2]; e.x = ram[4*i+3];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 128; i++) ram[i] = (i % 4 == 0) ? 8'hF0 : 8'($urandom);
  endtask

  task automatic set_obj(input int i, input logic [7:0] y, input logic [7:0] a,
                         input logic [7:0] c, input logic [7:0] x);
    ram[4*i] = y; ram[4*i+1] = a; ram[4*i+2] = c; ram[4*i+3] = x;
  endtask

  task automatic wait_cen_neg();
    do @(negedge clk); while (!cen2);
  endtask

  // Pulse hinit_x across exactly one cen2 edge and load the scoreboard.
  task automatic start_line(input logic [7:0] vr);
    wait_cen_neg();
    vrender = vr;
    push_scan(vr);
    hinit_x = 1'b1;
    @(posedge clk);
    #2;
    hinit_x = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int k;
    k = 0;
    while (!done && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_leftover"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_draw"}, 32'(dbus.draw), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_addr"}, 32'(obj_addr), 32'd0);
    chk({name, "_xpos"}, 32'(dbus.xpos), 32'd0);
    chk({name, "_ysub"}, 32'(dbus.ysub), 32'd0);
    chk({name, "_pal"},  32'(dbus.pal), 32'd0);
    chk({name, "_code"}, 32'(dbus.code), 32'd0);
    chk({name, "_flip"}, 32'({dbus.hflip, dbus.vflip}), 32'd0);
  endtask

  initial begin
    int cnt, base, k;
    logic [7:0] vr;
    rst = 1'b1; hinit_x = 1'b0; vrender = 8'd0;
    clear_ram();
    repeat (4) @(posedge clk);
    #3;
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check_reset_vals("post_reset");

    // All objects miss: done returns after 32 enabled edges, address walks down.
    cen_mode = 1;
    start_line(8'h40);
    chk("allmiss_busy", 32'(done), 32'd0);
    cnt = 0;
    while (!done && cnt < 64) begin
      wait_cen_neg();
      chk("allmiss_addr", 32'(obj_addr), 32'((31 - cnt) * 4));
      @(posedge clk);
      #2;
      cnt++;
    end
    chk("allmiss_edges", cnt, 32'd32);
    $display("allmiss: %0d enabled edges to done", cnt);
    chk("allmiss_nodraw", acc_count, 32'd0);

    // Single visible sprite.
    clear_ram();
    set_obj(5, 8'h38, 8'hC3, 8'h7A, 8'h90);
    base = acc_count;
    start_line(8'h40);
    wait_done("single", 400);
    chk("single_count", acc_count - base, 32'd1);

    // Two hits, draw stage stalls after the first acceptance.
    clear_ram();
    set_obj(9, 8'h3C, 8'h45, 8'h11, 8'h20);
    set_obj(2, 8'h31, 8'h9E, 8'h22, 8'hE0);
    base = acc_count;
    start_line(8'h40);
    k = 0;
    while (acc_count == base && k < 400) begin @(negedge clk); k++; end
    busy_mode = 2;
    repeat (20) begin wait_cen_neg(); @(posedge clk); #2; end
    chk("stall_draw_held", 32'(dbus.draw), 32'd1);
    chk("stall_one_accepted", acc_count - base, 32'd1);
    busy_mode = 0;
    wait_done("stall", 400);
    chk("stall_count", acc_count - base, 32'd2);

    // Y wrap-around hit, then a just-out-of-range miss.
    clear_ram();
    set_obj(7, 8'hF8, 8'h0D, 8'h33, 8'h44);
    base = acc_count;
    start_line(8'h02);
    wait_done("wrap", 400);
    chk("wrap_count", acc_count - base, 32'd1);
    clear_ram();
    set_obj(3, 8'h40, 8'h01, 8'h02, 8'h03);
    base = acc_count;
    start_line(8'h50);
    wait_done("edge_miss", 400);
    chk("edge_miss_count", acc_count - base, 32'd0);

    // Restart while object 20 waits for the draw stage.
    clear_ram();
    set_obj(20, 8'h40, 8'h55, 8'h66, 8'h77);
    busy_mode = 2;
    base = acc_count;
    start_line(8'h40);
    k = 0;
    while (!dbus.draw && k < 400) begin @(negedge clk); k++; end
    chk("abort_reached_draw", 32'(dbus.draw), 32'd1);
    wait_cen_neg();
    exp_q.delete();
    push_scan(8'h40);
    hinit_x = 1'b1;
    @(posedge clk);
    #2;
    hinit_x = 1'b0;
    chk("abort_draw", 32'(dbus.draw), 32'd0);
    chk("abort_addr", 32'(obj_addr), 32'h7C);
    chk("abort_done", 32'(done), 32'd0);
    busy_mode = 0;
    wait_done("abort", 400);
    chk("abort_count", acc_count - base, 32'd1);

    // Asynchronous reset in the code-fetch step.
    clear_ram();
    set_obj(12, 8'h3A, 8'hFF, 8'hAB, 8'hCD);
    base = acc_count;
    start_line(8'h40);
    k = 0;
    while (!(obj_addr[1:0] == 2'd2 && !done) && k < 400) begin @(negedge clk); k++; end
    chk("rst_reached_rc", 32'(obj_addr), 32'h32);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("midscan_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) begin wait_cen_neg(); @(posedge clk); #2; end
    check_reset_vals("after_reset_idle");
    chk("rst_count", acc_count - base, 32'd0);

    // Randomized lines with random enables and random stalls.
    busy_mode = 1;
    for (int line = 0; line < 8; line++) begin
      vr = 8'($urandom);
      for (int i = 0; i < 32; i++)
        set_obj(i, vr - 8'($urandom_range(0, 40)), 8'($urandom), 8'($urandom), 8'($urandom));
      base = acc_count;
      start_line(vr);
      wait_done("random", 4000);
      $display("random line %0d: vrender=%h accepted %0d", line, vr, acc_count - base);
    end
    busy_mode = 0;

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
